// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and writeback types.
// Reused by the register file, hazard unit and writeback arbiter.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/rf_writeback_arbiter_scoreboard.sv
// Pending-destination scoreboard for outstanding long-latency writes.
// Latency: set/clear visible one cycle after request. No backpressure.
// Set wins over clear on the same register; register 0 never pending.
module wb_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_vld,
    input  logic [REG_ADDR_W-1:0] set_dst,
    input  logic                  clr_vld,
    input  logic [REG_ADDR_W-1:0] clr_dst,
    output logic [NUM_REGS-1:0]   pending
);

    logic [NUM_REGS-1:0] pending_nxt;

    // Clear is applied first so a same-cycle reissue leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (clr_vld) begin
            pending_nxt[clr_dst] = 1'b0;
        end
        if (set_vld) begin
            pending_nxt[set_dst] = 1'b1;
        end
        pending_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and MEM writebacks into the single register-file write port.
// Latency: 1 cycle accept-to-write. Backpressure: losing source sees ready=0 and holds.
// MEM gains priority after STARVE_LIMIT consecutive refusals.
module rf_writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic [NUM_REGS-1:0]   pending
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    wb_req_t          alu_req;
    wb_req_t          mem_req;
    wb_req_t          win_req;
    wb_src_e          grant;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             accept;

    assign alu_req = '{dst: alu_reg, data: alu_data};
    assign mem_req = '{dst: mem_reg, data: mem_data};
    assign starved = (starve_cnt == STARVE_MAX);

    always_comb begin
        grant = WB_NONE;
        if (starved && mem_valid) begin
            grant = WB_MEM;
        end else if (alu_valid) begin
            grant = WB_ALU;
        end else if (mem_valid) begin
            grant = WB_MEM;
        end
    end

    always_comb begin
        win_req = alu_req;
        if (grant == WB_MEM) begin
            win_req = mem_req;
        end
    end

    assign alu_ready = (grant == WB_ALU);
    assign mem_ready = (grant == WB_MEM);
    assign accept    = (grant != WB_NONE);

    // Register 0 still completes its handshake and updates the address/data
    // registers, but never raises the write enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            RegWrite <= accept && (win_req.dst != ZERO_REG);
            if (accept) begin
                write_reg  <= win_req.dst;
                write_data <= win_req.data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (mem_ready) begin
            starve_cnt <= '0;
        end else if (mem_valid && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    wb_scoreboard u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_vld (issue_valid && (issue_reg != ZERO_REG)),
        .set_dst (issue_reg),
        .clr_vld (mem_ready && (mem_reg != ZERO_REG)),
        .clr_dst (mem_reg),
        .pending (pending)
    );

endmodule
